// File: rtl/bit_assembler_pkg.sv
// Shared constants for the serial-to-parallel bit assembler: word geometry
// and the two FSM state codes.
package bit_assembler_pkg;

  localparam int WORD_W = 16;
  localparam int IDX_W  = 4;

  localparam logic COLLECT = 1'b0;
  localparam logic HOLD    = 1'b1;

endpackage

// File: rtl/bit_index_counter.sv
// Bit position counter for the assembler. A high lock level presents the
// last position without disturbing the stored count.
module bit_index_counter #(
  parameter int IDX_W = bit_assembler_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  input  logic             lock,
  output logic [IDX_W-1:0] eff_idx
);

  logic [IDX_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + IDX_W'(1);
    end
  end

  assign eff_idx = lock ? '1 : count;

endmodule

// File: rtl/bit_assembler.sv
// Rebuilds an MSB-first serial bit stream into a parallel word and holds it
// until the consumer takes it.
module bit_assembler
  import bit_assembler_pkg::*;
#(
  parameter int WORD_W = bit_assembler_pkg::WORD_W,
  parameter int IDX_W  = bit_assembler_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              lock,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [IDX_W-1:0]  bit_index
);

  logic              state;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] next_shift;
  logic [IDX_W-1:0]  eff_idx;
  logic [IDX_W-1:0]  pos;
  logic              accept;
  logic              last;

  assign bit_ready  = (state == COLLECT);
  assign word_valid = (state == HOLD);
  assign accept     = bit_valid && bit_ready;
  assign last       = (eff_idx == IDX_W'(WORD_W - 1));
  assign pos        = IDX_W'(WORD_W - 1) - eff_idx;
  assign bit_index  = eff_idx;

  bit_index_counter #(
    .IDX_W (IDX_W)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (accept && !last),
    .clear   (accept && last),
    .lock    (lock),
    .eff_idx (eff_idx)
  );

  always_comb begin
    next_shift      = shift_reg;
    next_shift[pos] = bit_in;
  end

  // The final bit is merged straight into word_out so the word appears one
  // cycle after it; unwritten positions stay 0 because the shift register
  // is cleared at every word boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      shift_reg <= '0;
      word_out  <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (last) begin
              word_out  <= next_shift;
              shift_reg <= '0;
              state     <= HOLD;
            end else begin
              shift_reg <= next_shift;
            end
          end
        end
        default: begin
          if (word_ready) begin
            state <= COLLECT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_assembler.sv
// Self-checking bench for bit_assembler: a word-level reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_bit_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic        lock = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [3:0]  bit_index;

  int vectors = 0;
  int miscompares = 0;
  bit compare_en = 1'b0;

  // Reference model: number of bits received, the partial word, and the held word.
  int          m_count = 0;
  logic [15:0] m_partial = '0;
  logic [15:0] m_word = '0;
  bit          m_held = 1'b0;

  always #5 clk = ~clk;

  bit_assembler dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .lock       (lock),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bit_index  (bit_index)
  );

  always @(posedge clk) begin
    int eff;
    if (rst) begin
      m_count = 0; m_partial = '0; m_word = '0; m_held = 1'b0;
    end else if (m_held) begin
      if (word_ready) m_held = 1'b0;
    end else if (bit_valid) begin
      eff = lock ? 15 : m_count;
      m_partial[15 - eff] = bit_in;
      if (eff == 15) begin
        m_word = m_partial; m_held = 1'b1; m_count = 0; m_partial = '0;
      end else begin
        m_count = m_count + 1;
      end
    end
    compare_en = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("model bit_ready", 16'(bit_ready), 16'(!m_held));
      checkOutput("model word_valid", 16'(word_valid), 16'(m_held));
      checkOutput("model word_out", word_out, m_word);
      checkOutput("model bit_index", 16'(bit_index), lock ? 16'd15 : 16'(m_count));
    end
  end

  // Drive one cycle of inputs; returns just after the sampling edge.
  task automatic applyStimulus(input logic r, input logic bv, input logic bi, input logic lk, input logic wr);
    rst = r; bit_valid = bv; bit_in = bi; lock = lk; word_ready = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic streamWord(input logic [15:0] w, input logic wr);
    for (int i = 15; i >= 0; i--) applyStimulus(1'b0, 1'b1, w[i], 1'b0, wr);
  endtask

  initial begin
    logic [15:0] w;
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset bit_ready", 16'(bit_ready), 16'd1);
    checkOutput("reset word_valid", 16'(word_valid), 16'd0);
    checkOutput("reset word_out", word_out, 16'h0000);
    checkOutput("reset bit_index", 16'(bit_index), 16'd0);
    lock = 1'b1; #1;
    checkOutput("reset bit_index lock", 16'(bit_index), 16'd15);
    lock = 1'b0; #1;

    // Full 16-bit word, consumer always ready
    w = 16'hACF0;
    for (int i = 15; i >= 1; i--) applyStimulus(1'b0, 1'b1, w[i], 1'b0, 1'b1);
    checkOutput("ACF0 valid early", 16'(word_valid), 16'd0);
    applyStimulus(1'b0, 1'b1, w[0], 1'b0, 1'b1);
    checkOutput("ACF0 valid", 16'(word_valid), 16'd1);
    checkOutput("ACF0 word", word_out, 16'hACF0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ACF0 ready after", 16'(bit_ready), 16'd1);
    checkOutput("ACF0 valid after", 16'(word_valid), 16'd0);

    // Lock-terminated word
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("lock word", word_out, 16'hA001);
    checkOutput("lock valid", 16'(word_valid), 16'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("lock index after", 16'(bit_index), 16'd0);

    // Back-pressure while bits keep arriving
    streamWord(16'h530F, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("hold bit_ready", 16'(bit_ready), 16'd0);
      checkOutput("hold word", word_out, 16'h530F);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hold release valid", 16'(word_valid), 16'd0);
    checkOutput("hold no bits stored", 16'(bit_index), 16'd0);

    // Reset mid-word
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("midreset word", word_out, 16'h0000);
    checkOutput("midreset valid", 16'(word_valid), 16'd0);
    checkOutput("midreset index", 16'(bit_index), 16'd0);
    streamWord(16'hFFFF, 1'b0);
    checkOutput("FFFF word", word_out, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Gapped stream with lock-only cycles
    w = 16'h8001;
    for (int i = 15; i >= 0; i--) begin
      if (i % 3 == 0) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("gap index", 16'(bit_index), 16'(15 - i));
      end else if (i % 4 == 1) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, w[i], 1'b0, 1'b0);
    end
    checkOutput("8001 valid", 16'(word_valid), 16'd1);
    checkOutput("8001 word", word_out, 16'h8001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
